// File: rtl/e203_exu_fpu_fmis_cvtsw_if.sv
// Operand/result handshake bundle for the integer-to-single conversion unit.
// The master side is the producer of operands and consumer of results.
// The slave side is the conversion unit itself.
interface e203_exu_fpu_fmis_cvtsw_if;
    logic        fmis_cvtsw_i_valid;
    logic        fmis_cvtsw_i_ready;
    logic [31:0] fmis_i_rs1;
    logic        flag;
    logic        fmis_cvtsw_o_valid;
    logic        fmis_cvtsw_o_ready;
    logic [31:0] fmis_cvtsw_o_wbck_wdat;
    logic        fmis_cvtsw_o_inexact;

    modport master (
        output fmis_cvtsw_i_valid, fmis_i_rs1, flag, fmis_cvtsw_o_ready,
        input  fmis_cvtsw_i_ready, fmis_cvtsw_o_valid, fmis_cvtsw_o_wbck_wdat,
               fmis_cvtsw_o_inexact
    );

    modport slave (
        input  fmis_cvtsw_i_valid, fmis_i_rs1, flag, fmis_cvtsw_o_ready,
        output fmis_cvtsw_i_ready, fmis_cvtsw_o_valid, fmis_cvtsw_o_wbck_wdat,
               fmis_cvtsw_o_inexact
    );
endinterface

// File: rtl/e203_exu_fpu_fmis_cvtsw.sv
// fcvt.s.w / fcvt.s.wu: 32-bit integer to IEEE-754 binary32, 2-stage pipeline.
// S1 holds {sign, magnitude, leading-zero count}; S2 holds the packed result.
// Optional macro E203_FPU_CVTSW_RNE_EN selects round-to-nearest-even;
// the default build rounds toward zero. Inexact is reported in both builds.
module e203_exu_fpu_fmis_cvtsw (
    input  logic                          clk,
    input  logic                          rst_n,
    e203_exu_fpu_fmis_cvtsw_if.slave      bus
);

    // Stage 1 state
    logic        s1_valid;
    logic        s1_sign;
    logic [31:0] s1_mag;
    logic [4:0]  s1_lz;

    // Stage 2 state
    logic        s2_valid;
    logic [31:0] s2_wdat;
    logic        s2_inexact;

    // Handshake: each stage loads when empty or when its contents leave.
    logic s2_adv;
    logic s1_load;

    assign s2_adv                 = ~s2_valid | bus.fmis_cvtsw_o_ready;
    assign bus.fmis_cvtsw_i_ready = ~s1_valid | s2_adv;
    assign s1_load                = bus.fmis_cvtsw_i_valid & bus.fmis_cvtsw_i_ready;

    assign bus.fmis_cvtsw_o_valid     = s2_valid;
    assign bus.fmis_cvtsw_o_wbck_wdat = s2_wdat;
    assign bus.fmis_cvtsw_o_inexact   = s2_inexact;

    // Front end: sign extraction, absolute value and leading-zero count.
    logic        in_sign;
    logic [31:0] in_mag;
    logic [4:0]  in_lz;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        in_sign = ~bus.flag & bus.fmis_i_rs1[31];
        in_mag  = in_sign ? (~bus.fmis_i_rs1 + 32'd1) : bus.fmis_i_rs1;
        in_lz   = 5'd0;
        // Ascending scan: the highest set bit is the last to write in_lz.
        for (int i = 0; i < 32; i++) begin
            if (in_mag[i]) begin
                in_lz = 5'(31 - i);
            end
        end
    end

    // Back end: normalise, round and pack the S1 contents.
    logic [31:0] norm;
    logic [7:0]  exp_raw;
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        rnd_inc;
    logic [30:0] mag_rnd;
    logic [31:0] res_wdat;
    logic        res_inexact;

    always_comb begin
        norm    = s1_mag << s1_lz;
        exp_raw = 8'd158 - {3'd0, s1_lz};
        mant    = norm[30:8];
        guard   = norm[7];
        sticky  = |norm[6:0];
`ifdef E203_FPU_CVTSW_RNE_EN
        rnd_inc = guard & (sticky | mant[0]);
`else
        rnd_inc = 1'b0;
`endif
        // A mantissa overflow carries straight into the exponent field.
        mag_rnd = {exp_raw, mant} + {30'd0, rnd_inc};
        if (s1_mag == 32'd0) begin
            res_wdat    = 32'd0;
            res_inexact = 1'b0;
        end else begin
            res_wdat    = {s1_sign, mag_rnd};
            res_inexact = guard | sticky;
        end
    end

    // Stage 1 register: capture the decoded operand on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= 32'd0;
            s1_lz    <= 5'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (bus.fmis_cvtsw_i_ready) begin
                s1_valid <= bus.fmis_cvtsw_i_valid;
            end
            if (s1_load) begin
                s1_sign <= in_sign;
                s1_mag  <= in_mag;
                s1_lz   <= in_lz;
            end
        end
    end

    // Stage 2 register: capture the packed result when S1 advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: result data is reset as well so the output bus reads zero during reset.
            s2_valid   <= 1'b0;
            s2_wdat    <= 32'd0;
            s2_inexact <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_wdat    <= res_wdat;
                s2_inexact <= res_inexact;
            end
        end
    end

endmodule

// File: tb/tb_e203_exu_fpu_fmis_cvtsw.sv
// Directed-vector bench for e203_exu_fpu_fmis_cvtsw.
// Expected results are hand-computed; rounding-dependent ones follow
// E203_FPU_CVTSW_RNE_EN exactly as the design build does.
module tb_e203_exu_fpu_fmis_cvtsw;

    logic clk;
    logic rst_n;

    e203_exu_fpu_fmis_cvtsw_if bus ();

    e203_exu_fpu_fmis_cvtsw dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NV = 10;
    logic [31:0] v_rs1 [NV];
    logic        v_flag[NV];
    logic [31:0] v_exp [NV];
    logic        v_nx  [NV];

    int n_vec;
    int n_err;
    int idx;
    int outc;
    int n_items;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full-latency conversion on an empty pipeline with o_ready=1.
    task automatic convert(input int k);
        bus.fmis_cvtsw_i_valid = 1'b1;
        bus.fmis_i_rs1         = v_rs1[k];
        bus.flag               = v_flag[k];
        @(negedge clk);
        check($sformatf("v%0d_iready", k), 32'(bus.fmis_cvtsw_i_ready), 32'd1);
        @(posedge clk); #1;
        bus.fmis_cvtsw_i_valid = 1'b0;
        check($sformatf("v%0d_lat1", k), 32'(bus.fmis_cvtsw_o_valid), 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_ovalid", k), 32'(bus.fmis_cvtsw_o_valid), 32'd1);
        check($sformatf("v%0d_wdat", k), bus.fmis_cvtsw_o_wbck_wdat, v_exp[k]);
        check($sformatf("v%0d_nx", k), 32'(bus.fmis_cvtsw_o_inexact), 32'(v_nx[k]));
        @(posedge clk); #1;
    endtask

    // One streaming cycle: offer the next operand, retire a result if it leaves.
    task automatic step();
        logic rdy, ov, ord, nx;
        logic [31:0] dat;
        bus.fmis_cvtsw_i_valid = (idx < n_items);
        bus.fmis_i_rs1         = (idx < n_items) ? v_rs1[idx] : 32'd0;
        bus.flag               = (idx < n_items) ? v_flag[idx] : 1'b0;
        @(negedge clk);
        rdy = bus.fmis_cvtsw_i_ready;
        ov  = bus.fmis_cvtsw_o_valid;
        ord = bus.fmis_cvtsw_o_ready;
        dat = bus.fmis_cvtsw_o_wbck_wdat;
        nx  = bus.fmis_cvtsw_o_inexact;
        @(posedge clk);
        if (bus.fmis_cvtsw_i_valid && rdy) idx++;
        if (ov && ord) begin
            check($sformatf("stream%0d_wdat", outc), dat, v_exp[outc]);
            check($sformatf("stream%0d_nx", outc), 32'(nx), 32'(v_nx[outc]));
            outc++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [31:0] held;
        logic seen;

        v_rs1[0] = 32'h0000_0001; v_flag[0] = 1'b0; v_exp[0] = 32'h3F80_0000; v_nx[0] = 1'b0;
        v_rs1[1] = 32'hFFFF_FFFF; v_flag[1] = 1'b0; v_exp[1] = 32'hBF80_0000; v_nx[1] = 1'b0;
        v_rs1[2] = 32'h0000_0000; v_flag[2] = 1'b0; v_exp[2] = 32'h0000_0000; v_nx[2] = 1'b0;
        v_rs1[3] = 32'h8000_0000; v_flag[3] = 1'b0; v_exp[3] = 32'hCF00_0000; v_nx[3] = 1'b0;
        v_rs1[4] = 32'h8000_0000; v_flag[4] = 1'b1; v_exp[4] = 32'h4F00_0000; v_nx[4] = 1'b0;
        v_rs1[7] = 32'h0100_0001; v_flag[7] = 1'b0; v_exp[7] = 32'h4B80_0000; v_nx[7] = 1'b1;
        v_rs1[9] = 32'hFFFF_FFFB; v_flag[9] = 1'b0; v_exp[9] = 32'hC0A0_0000; v_nx[9] = 1'b0;
        v_rs1[5] = 32'hFFFF_FFFF; v_flag[5] = 1'b1; v_nx[5] = 1'b1;
        v_rs1[6] = 32'h0100_0003; v_flag[6] = 1'b0; v_nx[6] = 1'b1;
        v_rs1[8] = 32'h7FFF_FFFF; v_flag[8] = 1'b0; v_nx[8] = 1'b1;
`ifdef E203_FPU_CVTSW_RNE_EN
        v_exp[5] = 32'h4F80_0000;
        v_exp[6] = 32'h4B80_0002;
        v_exp[8] = 32'h4F00_0000;
`else
        v_exp[5] = 32'h4F7F_FFFF;
        v_exp[6] = 32'h4B80_0001;
        v_exp[8] = 32'h4EFF_FFFF;
`endif

        n_vec = 0;
        n_err = 0;
        bus.fmis_cvtsw_i_valid = 1'b0;
        bus.fmis_i_rs1         = 32'd0;
        bus.flag               = 1'b0;
        bus.fmis_cvtsw_o_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovalid", 32'(bus.fmis_cvtsw_o_valid), 32'd0);
        check("rst_wdat", bus.fmis_cvtsw_o_wbck_wdat, 32'd0);
        check("rst_nx", 32'(bus.fmis_cvtsw_o_inexact), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_iready", 32'(bus.fmis_cvtsw_i_ready), 32'd1);
        @(posedge clk); #1;

        // Single conversions with full latency checks
        for (int k = 0; k < NV; k++) convert(k);

        // Full-throughput stream with o_ready held high
        idx = 0; outc = 0; n_items = NV; cyc = 0;
        while (outc < NV && cyc < 60) begin
            step();
            cyc++;
        end
        check("tput_count", 32'(outc), 32'(NV));
        check("tput_cycles_ok", 32'(cyc <= NV + 3), 32'd1);

        // Backpressure: o_ready low for 3 cycles while 4 operands are offered
        idx = 0; outc = 0; n_items = 4;
        bus.fmis_cvtsw_o_ready = 1'b0;
        repeat (3) step();
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_iready_low", 32'(bus.fmis_cvtsw_i_ready), 32'd0);
        check("bp_ovalid", 32'(bus.fmis_cvtsw_o_valid), 32'd1);
        held = bus.fmis_cvtsw_o_wbck_wdat;
        check("bp_head", held, v_exp[0]);
        step();
        check("bp_hold_wdat", bus.fmis_cvtsw_o_wbck_wdat, v_exp[0]);
        check("bp_hold_nx", 32'(bus.fmis_cvtsw_o_inexact), 32'(v_nx[0]));
        bus.fmis_cvtsw_o_ready = 1'b1;
        cyc = 0;
        while (outc < 4 && cyc < 40) begin
            step();
            cyc++;
        end
        check("bp_all_out", 32'(outc), 32'd4);

        // Reset while both stages hold conversions
        idx = 0; outc = 0; n_items = 2;
        bus.fmis_cvtsw_o_ready = 1'b0;
        repeat (3) step();
        check("mid_full_iready", 32'(bus.fmis_cvtsw_i_ready), 32'd0);
        check("mid_full_ovalid", 32'(bus.fmis_cvtsw_o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ovalid", 32'(bus.fmis_cvtsw_o_valid), 32'd0);
        check("mid_rst_wdat", bus.fmis_cvtsw_o_wbck_wdat, 32'd0);
        check("mid_rst_nx", 32'(bus.fmis_cvtsw_o_inexact), 32'd0);
        bus.fmis_cvtsw_i_valid = 1'b0;
        bus.fmis_cvtsw_o_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_iready", 32'(bus.fmis_cvtsw_i_ready), 32'd1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.fmis_cvtsw_o_valid) seen = 1'b1;
        end
        check("mid_no_stale", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
